reg_file_scoreboard: RTL and testbench
======================================

# reg_file_scoreboard

Register file for the pipelined datapath with a one-hot write-address decoder, two combinational read ports with write-through bypass, and a per-register pending-write scoreboard. It consumes the 5-bit destination-register index chosen by the destination-select mux in decode, at issue and again at writeback. It is the write and read end of the register-address path. It also produces the decode-stage stall signal for RAW and WAW hazards on in-flight destinations.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W = 32

- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset
- ReadRegA  in  ADDR_W  read port A index
- ReadRegB  in  ADDR_W  read port B index
- ReadDataA  out  DATA_W  port A data, combinational
- ReadDataB  out  DATA_W  port B data, combinational
- BusyA  out  1  register ReadRegA has an uncompleted pending write
- BusyB  out  1  register ReadRegB has an uncompleted pending write
- IssueValid  in  1  an instruction with a destination register issues this cycle
- IssueReg  in  ADDR_W  destination index, from the destination-select mux
- Stall  out  1  issue blocked this cycle
- WriteEn  in  1  writeback valid
- WriteReg  in  ADDR_W  writeback index
- WriteData  in  DATA_W  writeback data
- PendingCount  out  ADDR_W+1  number of set pending bits (0..31)

## Operation
- Storage: 32 × DATA_W registers plus 32 pending bits. Register 0 reads as 0, is never written and is never pending.
- Write: when WriteEn=1 and WriteReg≠0, the decoder produces a one-hot enable. Regs[WriteReg] ← WriteData and Pending[WriteReg] ← 0 at the clock edge.
- Read bypass: if WriteEn=1, WriteReg≠0 and ReadRegX==WriteReg, ReadDataX = WriteData. Otherwise ReadDataX = Regs[ReadRegX].
- BusyX = Pending[ReadRegX] & ~(WriteEn & WriteReg==ReadRegX). A same-cycle writeback hides the busy bit.
- Stall = IssueValid & (BusyA | BusyB | BusyIssue). BusyIssue is Pending[IssueReg] with the same same-cycle-writeback masking (WAW).
- Issue: when IssueValid=1, Stall=0 and IssueReg≠0, Pending[IssueReg] ← 1 at the edge. A stalled issue changes nothing.
- Same register in issue and writeback in one cycle: the data is written and the pending bit ends at 1, because the new producer wins.
- PendingCount tracks the registered popcount, updated incrementally by +1 on set, −1 on clear, and 0 when both or neither apply to distinct or identical registers. It never exceeds 31 and never underflows.
- A writeback to a register that is not pending writes the data, leaves the bit at 0 and leaves the count unchanged.

## Timing
- Reset (Rst=0, async): all Regs=0, all Pending=0, PendingCount=0. Hence ReadDataA/B=0, BusyA/B=0 and Stall=0 immediately, independent of Clk.
- Reset deasserts synchronously to the Clk edge. The first write is accepted on the first edge with Rst=1.
- Write latency: 0 cycles to the read ports via bypass; stored at the next edge.
- Issue latency: the pending bit is visible on BusyX one cycle after the accepted issue edge.
- Reset mid-operation clears all stored data and all pending bits in the same cycle. In-flight writebacks after reset simply write data; the count stays 0.
- No combinational path from Stall back into the issue inputs is assumed inside the block. Stall depends only on inputs and registered state.

## Structure
- Package regfile_pkg:
  - DATA_W, ADDR_W, NUM_REGS
  - ZERO_REG = 5'd0
  - index typedef reg_idx_t (logic [ADDR_W-1:0])
- Sub-module decoder_5to32: combinational, inputs En and Idx, output one-hot 32-bit enable with bit 0 forced low. It is shared by the write path and the issue (pending-set) path as two instances.

## Test plan
- Reset with random prior state → all ReadData=0, Busy=0, PendingCount=0, even while Clk is stopped.
- Write R5=0xDEADBEEF while reading R5 on port A → ReadDataA=0xDEADBEEF in the same cycle; after the edge, reading with WriteEn=0 still returns 0xDEADBEEF. Write R0=0x1234 → R0 reads 0.
- Issue R7; next cycle read R7 on port B → BusyB=1; a second issue to R3 with ReadRegA=7 → Stall=1, R3 not marked, PendingCount stays 1.
- Writeback R7 in the same cycle as the dependent issue → BusyB=0, Stall=0, data bypassed; after the edge R7 is not pending and PendingCount=1 (the dependent's destination is now pending).
- Issue R9 and writeback R9 in the same cycle while R9 is pending → data stored, R9 still pending, PendingCount unchanged.
- Issue 31 distinct registers → PendingCount=31; reset asserted mid-sequence → count=0 and Busy=0 asynchronously.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and index type for the register file and its scoreboard.
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/decoder_5to32.sv
// One-hot index decoder; register 0 never gets an enable.
module decoder_5to32
   import regfile_pkg::*;
(
   input  logic                En,
   input  reg_idx_t            Idx,
   output logic [NUM_REGS-1:0] OneHot
);

   always_comb begin
      OneHot = '0;
      if (En && (Idx != ZERO_REG)) begin
         OneHot[Idx] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with write-through read bypass and a pending-write scoreboard
// that raises the decode stall on RAW/WAW hazards against in-flight destinations.
module reg_file_scoreboard
   import regfile_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  reg_idx_t          ReadRegA,
   input  reg_idx_t          ReadRegB,
   output logic [DATA_W-1:0] ReadDataA,
   output logic [DATA_W-1:0] ReadDataB,
   output logic              BusyA,
   output logic              BusyB,
   input  logic              IssueValid,
   input  reg_idx_t          IssueReg,
   output logic              Stall,
   input  logic              WriteEn,
   input  reg_idx_t          WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   output logic [ADDR_W:0]   PendingCount
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] wr_hot;
   logic [NUM_REGS-1:0] set_hot;
   logic [ADDR_W:0]     pend_cnt;

   logic wr_match_a;
   logic wr_match_b;
   logic wr_match_issue;
   logic busy_issue;
   logic issue_ok;
   logic cnt_inc;
   logic cnt_dec;

   assign wr_match_a     = WriteEn && (WriteReg == ReadRegA);
   assign wr_match_b     = WriteEn && (WriteReg == ReadRegB);
   assign wr_match_issue = WriteEn && (WriteReg == IssueReg);

   // A writeback landing this cycle retires the old producer, so it hides the busy bit.
   assign BusyA      = pending[ReadRegA] & ~wr_match_a;
   assign BusyB      = pending[ReadRegB] & ~wr_match_b;
   assign busy_issue = pending[IssueReg] & ~wr_match_issue;

   assign Stall    = IssueValid & (BusyA | BusyB | busy_issue);
   assign issue_ok = IssueValid & ~Stall;

   assign ReadDataA = (wr_match_a && (WriteReg != ZERO_REG)) ? WriteData : regs[ReadRegA];
   assign ReadDataB = (wr_match_b && (WriteReg != ZERO_REG)) ? WriteData : regs[ReadRegB];

   decoder_5to32 u_wr_dec (
      .En     (WriteEn),
      .Idx    (WriteReg),
      .OneHot (wr_hot)
   );

   decoder_5to32 u_set_dec (
      .En     (issue_ok),
      .Idx    (IssueReg),
      .OneHot (set_hot)
   );

   // An accepted issue always targets a bit that is clear or being cleared this
   // cycle, so the set and clear terms alone give the exact popcount delta.
   assign cnt_inc = |set_hot;
   assign cnt_dec = |(wr_hot & pending);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pending  <= '0;
         pend_cnt <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         pending <= (pending & ~wr_hot) | set_hot;
         case ({cnt_inc, cnt_dec})
            2'b10:   pend_cnt <= pend_cnt + (ADDR_W+1)'(1);
            2'b01:   pend_cnt <= pend_cnt - (ADDR_W+1)'(1);
            default: pend_cnt <= pend_cnt;
         endcase
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hot[i]) begin
               regs[i] <= WriteData;
            end
         end
      end
   end

   assign PendingCount = pend_cnt;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: stimulus queues hand-computed expectations, a monitor pops
// and compares them against the combinational outputs.
module tb_reg_file_scoreboard;
   import regfile_pkg::*;

   logic              Clk = 1'b0;
   logic              Rst;
   reg_idx_t          ReadRegA, ReadRegB, IssueReg, WriteReg;
   logic [DATA_W-1:0] ReadDataA, ReadDataB, WriteData;
   logic              BusyA, BusyB, IssueValid, Stall, WriteEn;
   logic [ADDR_W:0]   PendingCount;

   typedef struct {
      string             name;
      logic [DATA_W-1:0] rda;
      logic [DATA_W-1:0] rdb;
      logic              ba;
      logic              bb;
      logic              st;
      logic [ADDR_W:0]   cnt;
   } exp_t;

   exp_t exp_q[$];
   event chk_ev;
   int   vectors     = 0;
   int   miscompares = 0;
   bit   clk_en      = 1'b1;

   reg_file_scoreboard dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .ReadRegA     (ReadRegA),
      .ReadRegB     (ReadRegB),
      .ReadDataA    (ReadDataA),
      .ReadDataB    (ReadDataB),
      .BusyA        (BusyA),
      .BusyB        (BusyB),
      .IssueValid   (IssueValid),
      .IssueReg     (IssueReg),
      .Stall        (Stall),
      .WriteEn      (WriteEn),
      .WriteReg     (WriteReg),
      .WriteData    (WriteData),
      .PendingCount (PendingCount)
   );

   always begin
      #5;
      if (clk_en) Clk = ~Clk;
   end

   task automatic drive(input reg_idx_t ra, input reg_idx_t rb, input logic iv,
                        input reg_idx_t ir, input logic we, input reg_idx_t wr,
                        input logic [DATA_W-1:0] wd);
      ReadRegA   = ra;
      ReadRegB   = rb;
      IssueValid = iv;
      IssueReg   = ir;
      WriteEn    = we;
      WriteReg   = wr;
      WriteData  = wd;
   endtask

   task automatic expect_v(input string name, input logic [DATA_W-1:0] rda,
                           input logic [DATA_W-1:0] rdb, input logic ba, input logic bb,
                           input logic st, input logic [ADDR_W:0] cnt);
      exp_t e;
      e.name = name; e.rda = rda; e.rdb = rdb;
      e.ba = ba; e.bb = bb; e.st = st; e.cnt = cnt;
      exp_q.push_back(e);
      -> chk_ev;
      #2;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(chk_ev);
         #1;
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({ReadDataA, ReadDataB, BusyA, BusyB, Stall, PendingCount} !==
                {e.rda, e.rdb, e.ba, e.bb, e.st, e.cnt}) begin
               miscompares++;
               $display("FAIL %s: got rda=%h rdb=%h ba=%b bb=%b stall=%b cnt=%0d, expected rda=%h rdb=%h ba=%b bb=%b stall=%b cnt=%0d",
                        e.name, ReadDataA, ReadDataB, BusyA, BusyB, Stall, PendingCount,
                        e.rda, e.rdb, e.ba, e.bb, e.st, e.cnt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      #12;
      @(negedge Clk); Rst = 1'b1;

      // Build some state, then reset with the clock stopped
      @(negedge Clk); drive(0, 0, 1, 12, 1, 5, $urandom | 32'h1);
      @(negedge Clk); drive(0, 0, 1, 20, 0, 0, 0);
      @(negedge Clk); drive(12, 20, 0, 0, 0, 0, 0);
      expect_v("pre_reset_busy", 0, 0, 1, 1, 0, 2);
      clk_en = 1'b0;
      #1;
      Rst = 1'b0;
      drive(5, 12, 1, 20, 0, 0, 0);
      expect_v("reset_clk_stopped", 0, 0, 0, 0, 0, 0);
      #20;
      expect_v("reset_held_clk_stopped", 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      Rst    = 1'b1;
      clk_en = 1'b1;

      // Write bypass and register 0
      @(negedge Clk); drive(5, 0, 0, 0, 1, 5, 32'hDEADBEEF);
      expect_v("bypass_r5", 32'hDEADBEEF, 0, 0, 0, 0, 0);
      @(negedge Clk); drive(5, 0, 0, 0, 0, 0, 0);
      expect_v("stored_r5", 32'hDEADBEEF, 0, 0, 0, 0, 0);
      @(negedge Clk); drive(0, 5, 0, 0, 1, 0, 32'h1234);
      expect_v("write_r0_bypass", 0, 32'hDEADBEEF, 0, 0, 0, 0);
      @(negedge Clk); drive(0, 5, 0, 0, 0, 0, 0);
      expect_v("r0_reads_zero", 0, 32'hDEADBEEF, 0, 0, 0, 0);

      // RAW stall on R7
      @(negedge Clk); drive(0, 0, 1, 7, 0, 0, 0);
      expect_v("issue_r7", 0, 0, 0, 0, 0, 0);
      @(negedge Clk); drive(0, 7, 0, 0, 0, 0, 0);
      expect_v("busy_r7", 0, 0, 0, 1, 0, 1);
      @(negedge Clk); drive(7, 0, 1, 3, 0, 0, 0);
      expect_v("raw_stall", 0, 0, 1, 0, 1, 1);
      @(negedge Clk); drive(3, 7, 0, 0, 0, 0, 0);
      expect_v("r3_not_marked", 0, 0, 0, 1, 0, 1);

      // Writeback of R7 alongside the dependent issue
      @(negedge Clk); drive(7, 7, 1, 3, 1, 7, 32'hCAFEF00D);
      expect_v("wb_hides_busy", 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 1);
      @(negedge Clk); drive(7, 3, 0, 0, 0, 0, 0);
      expect_v("after_wb_r7", 32'hCAFEF00D, 0, 0, 1, 0, 1);

      // Issue and writeback to the same pending register
      @(negedge Clk); drive(0, 0, 1, 9, 0, 0, 0);
      expect_v("issue_r9", 0, 0, 0, 0, 0, 1);
      @(negedge Clk); drive(9, 0, 1, 9, 1, 9, 32'h99AA55CC);
      expect_v("issue_wb_same_reg", 32'h99AA55CC, 0, 0, 0, 0, 2);
      @(negedge Clk); drive(9, 3, 0, 0, 0, 0, 0);
      expect_v("same_reg_still_pending", 32'h99AA55CC, 0, 1, 1, 0, 2);
      @(negedge Clk); drive(0, 0, 1, 9, 0, 0, 0);
      expect_v("waw_stall", 0, 0, 0, 0, 1, 2);
      @(negedge Clk); drive(5, 0, 0, 0, 1, 5, 32'h11112222);
      expect_v("wb_not_pending", 32'h11112222, 0, 0, 0, 0, 2);
      @(negedge Clk); drive(5, 0, 0, 0, 0, 0, 0);
      expect_v("wb_not_pending_after", 32'h11112222, 0, 0, 0, 0, 2);
      @(negedge Clk); drive(3, 9, 0, 0, 1, 3, 32'h33);
      expect_v("clear_r3", 32'h33, 32'h99AA55CC, 0, 1, 0, 2);
      @(negedge Clk); drive(3, 9, 0, 0, 1, 9, 32'h99);
      expect_v("clear_r9", 32'h33, 32'h99, 0, 0, 0, 1);
      @(negedge Clk); drive(3, 9, 0, 0, 0, 0, 0);
      expect_v("all_clear", 32'h33, 32'h99, 0, 0, 0, 0);

      // Fill all 31 pending bits
      for (int i = 1; i < NUM_REGS; i++) begin
         @(negedge Clk); drive(0, 0, 1, reg_idx_t'(i), 0, 0, 0);
         expect_v("issue_fill", 0, 0, 0, 0, 0, (ADDR_W+1)'(i - 1));
      end
      @(negedge Clk); drive(0, 0, 1, 0, 0, 0, 0);
      expect_v("issue_r0_at_full", 0, 0, 0, 0, 0, 31);
      @(negedge Clk); drive(1, 31, 0, 0, 0, 0, 0);
      expect_v("full_busy", 0, 0, 1, 1, 0, 31);

      // Asynchronous reset away from any clock edge
      @(negedge Clk); #2;
      Rst = 1'b0;
      drive(5, 17, 1, 4, 0, 0, 0);
      expect_v("async_reset_mid", 0, 0, 0, 0, 0, 0);
      @(negedge Clk); Rst = 1'b1;
      drive(0, 17, 0, 0, 1, 17, 32'hABCD);
      expect_v("wb_after_reset", 0, 32'hABCD, 0, 0, 0, 0);
      @(negedge Clk); drive(0, 17, 0, 0, 0, 0, 0);
      expect_v("wb_after_reset_stored", 0, 32'hABCD, 0, 0, 0, 0);

      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
